// File: rtl/multiplier_result_accumulator.sv
// Unpacks SIMD multiplier result beats per mode and accumulates per-lane totals
// over a packet, presenting them on a valid/ready output.
//
// state | meaning
// IDLE  | no packet open; next beat leaving S1 starts one and latches mode/sign
// ACCUM | packet open, beats from S1 accumulate into the lane totals
// FINAL | last beat folded in; one cycle before the result is presented
// DONE  | out_valid high, totals held until out_ready
module multiplier_result_accumulator #(
  parameter int ACC_W     = 40,
  parameter bit SATURATE  = 1'b1,
  parameter int MAX_BEATS = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [1:0]       mode,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic [19:0]      result_0,
  input  logic [19:0]      result_1,
  input  logic [1:0]       result_SIDM_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_0,
  output logic [ACC_W-1:0] acc_1,
  output logic [7:0]       beat_count,
  output logic             ovf_0,
  output logic             ovf_1,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

  state_t state_q, state_d;

  logic        s1_valid, s1_last, s1_s;
  logic [1:0]  s1_mode, s1_carry;
  logic [19:0] s1_r0;
  logic [5:0]  s1_r1h;

  logic [1:0]       pkt_mode;
  logic             pkt_s;
  logic [ACC_W-1:0] acc0_q, acc1_q;
  logic [7:0]       cnt_q;
  logic             ovf0_q, ovf1_q, err_q;

  logic             drain_ok, drain, first, accept, close, beat_err;
  logic [1:0]       dec_mode;
  logic             dec_s;
  logic [20:0]      sum21;
  logic [14:0]      l0_15;
  logic [6:0]       l1_7;
  logic [ACC_W-1:0] lane0, lane1;
  logic [ACC_W:0]   add0, add1;
  logic [7:0]       cnt_next;
  logic             unused_r1;

  assign unused_r1 = ^result_1[13:0];

  // Beats only leave S1 while a packet can absorb them, so a beat captured
  // during FINAL/DONE waits there for the next packet.
  assign drain_ok = (state_q == IDLE) || (state_q == ACCUM);
  assign drain    = s1_valid && drain_ok;
  assign first    = (state_q == IDLE);
  assign in_ready = ~(out_valid & ~out_ready) & ~(s1_valid & (s1_last | ~drain_ok));
  assign accept   = in_valid && in_ready;

  assign dec_mode = first ? s1_mode : pkt_mode;
  assign dec_s    = first ? s1_s : pkt_s;

  always_comb begin
    sum21 = {s1_carry[1], s1_r1h, 14'h0} + {7'h0, s1_r0[13:0]} + {6'h0, s1_carry[0], 14'h0};
    l0_15 = {s1_carry[0], s1_r0[13:0]};
    l1_7  = {s1_carry[1], s1_r1h};
    lane0 = '0;
    lane1 = '0;
    case (dec_mode)
      2'b00: lane0 = dec_s ? ACC_W'($signed(s1_r0)) : ACC_W'(s1_r0);
      2'b01: lane0 = dec_s ? ACC_W'($signed(sum21)) : ACC_W'(sum21);
      2'b10: begin
        lane0 = dec_s ? ACC_W'($signed(l0_15)) : ACC_W'(l0_15);
        lane1 = dec_s ? ACC_W'($signed(l1_7)) : ACC_W'(l1_7);
      end
      default: begin
        lane0 = '0;
        lane1 = '0;
      end
    endcase
  end

  // Returns {overflow, new_total}; the sum is formed one bit wider than the
  // accumulator so the true result is available for the overflow decision.
  function automatic logic [ACC_W:0] add_lane(input logic [ACC_W-1:0] acc,
                                              input logic [ACC_W-1:0] lane,
                                              input logic s);
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sat;
    logic             ovf;
    sum = {s & acc[ACC_W-1], acc} + {s & lane[ACC_W-1], lane};
    if (s) begin
      ovf = sum[ACC_W] ^ sum[ACC_W-1];
      sat = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf = sum[ACC_W];
      sat = {ACC_W{1'b1}};
    end
    if (ovf && SATURATE) return {1'b1, sat};
    return {ovf, sum[ACC_W-1:0]};
  endfunction

  always_comb begin
    add0     = add_lane(first ? '0 : acc0_q, lane0, dec_s);
    add1     = add_lane(first ? '0 : acc1_q, lane1, dec_s);
    cnt_next = (first ? 8'd0 : cnt_q) + 8'd1;
    close    = s1_last || (cnt_next == 8'(MAX_BEATS));
    beat_err = (s1_mode == 2'b11)
             || (!first && ((s1_mode != pkt_mode) || (s1_s != pkt_s)))
             || (close && !s1_last);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (drain) state_d = close ? FINAL : ACCUM;
      ACCUM:   if (drain && close) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_s     <= 1'b0;
      s1_mode  <= 2'b00;
      s1_carry <= 2'b00;
      s1_r0    <= '0;
      s1_r1h   <= '0;
      pkt_mode <= 2'b00;
      pkt_s    <= 1'b0;
      acc0_q   <= '0;
      acc1_q   <= '0;
      cnt_q    <= '0;
      ovf0_q   <= 1'b0;
      ovf1_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        s1_valid <= 1'b1;
        s1_last  <= in_last;
        s1_s     <= a_sign | b_sign;
        s1_mode  <= mode;
        s1_carry <= result_SIDM_carry;
        s1_r0    <= result_0;
        s1_r1h   <= result_1[19:14];
      end else if (drain) begin
        s1_valid <= 1'b0;
      end

      if (drain) begin
        acc0_q <= add0[ACC_W-1:0];
        acc1_q <= add1[ACC_W-1:0];
        ovf0_q <= (!first && ovf0_q) || add0[ACC_W];
        ovf1_q <= (!first && ovf1_q) || add1[ACC_W];
        err_q  <= (!first && err_q) || beat_err;
        cnt_q  <= cnt_next;
        if (first) begin
          pkt_mode <= s1_mode;
          pkt_s    <= s1_s;
        end
      end else if (state_q == DONE && out_ready) begin
        acc0_q <= '0;
        acc1_q <= '0;
        ovf0_q <= 1'b0;
        ovf1_q <= 1'b0;
        err_q  <= 1'b0;
        cnt_q  <= '0;
      end
    end
  end

  assign out_valid  = (state_q == DONE);
  assign acc_0      = acc0_q;
  assign acc_1      = acc1_q;
  assign beat_count = cnt_q;
  assign ovf_0      = ovf0_q;
  assign ovf_1      = ovf1_q;
  assign err        = err_q;

endmodule
